weight_sram_ctrl: RTL and testbench
===================================

WEIGHT_SRAM_CTRL -- requirements
Module: weight_sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 18: weight word address width.
REQ-002 SHALL have parameter DEPTH, default 196608: number of valid 16-bit words, equal to six banks of 32768.
REQ-003 SHALL have parameter LEN_W, default 16: burst length field width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port wr_valid, input, 1: loader write request.
REQ-007 SHALL have port wr_ready, output, 1: write accepted this cycle.
REQ-008 SHALL have port wr_addr, input, ADDR_W: write address.
REQ-009 SHALL have port wr_data, input, 16: write data.
REQ-010 SHALL have port rd_req, input, 1: fetcher burst request.
REQ-011 SHALL have port rd_addr, input, ADDR_W: burst start address.
REQ-012 SHALL have port rd_len, input, LEN_W: burst length in words; 0 is illegal.
REQ-013 SHALL have port rd_ack, output, 1: one-cycle pulse when a burst is accepted.
REQ-014 SHALL have port rd_stall, input, 1: fetcher backpressure that holds address issue.
REQ-015 SHALL have port rd_dvalid, output, 1: rd_data is valid.
REQ-016 SHALL have port rd_data, output, 16: read word, equal to mem_rdata[15:0].
REQ-017 SHALL have port rd_done, output, 1: one-cycle pulse together with the last rd_dvalid of a burst.
REQ-018 SHALL have port err, output, 1: sticky address/length error.
REQ-019 SHALL have port err_clr, input, 1: clears err.
REQ-020 SHALL have port mem_cs, output, 1: SRAM chip select.
REQ-021 SHALL have port mem_oe, output, 1: SRAM output enable.
REQ-022 SHALL have port mem_web, output, 1: SRAM write enable, active-low.
REQ-023 SHALL have port mem_addr, output, 32: SRAM address; bits above ADDR_W are 0.
REQ-024 SHALL have port mem_wdata, output, 32: SRAM write data; upper 16 bits are 0.
REQ-025 SHALL have port mem_rdata, input, 32: SRAM read data, returned one cycle after the address is issued.

Function
REQ-026 SHALL implement FSM states IDLE, WRITE, READ and DRAIN.
REQ-027 In IDLE, a request SHALL be accepted only in IDLE; with both wr_valid and rd_req high, it SHALL grant the opposite of the last grant, and write SHALL win after reset.
REQ-028 When a write is granted, wr_ready SHALL pulse in the same cycle and the FSM SHALL go to WRITE for exactly one cycle: mem_cs=1, mem_web=0, mem_oe=0, with the address and data registered from the accept cycle; WRITE SHALL then return to IDLE.
REQ-029 When a read is granted, rd_ack SHALL pulse; it SHALL latch base=rd_addr and remaining=rd_len, then go to READ.
REQ-030 In READ with rd_stall=0: mem_cs=1, mem_oe=1, mem_web=1, mem_addr=current address; the address SHALL increment and remaining SHALL decrement; when remaining reaches 1 at issue, the FSM SHALL go to DRAIN.
REQ-031 In READ with rd_stall=1: mem_cs=0 and address and remaining SHALL be held; mem_oe SHALL still be 1 if an issue occurred in the previous cycle.
REQ-032 rd_dvalid SHALL be 1 exactly one cycle after each issue cycle; mem_oe SHALL be 1 during that cycle.
REQ-033 DRAIN SHALL last one cycle: mem_cs=0, mem_oe=1, rd_dvalid=1, rd_done=1; DRAIN SHALL then return to IDLE.
REQ-034 Outside WRITE and READ issue cycles: mem_cs=0, mem_web=1.
REQ-035 On a write with wr_addr>=DEPTH: wr_ready SHALL pulse, no SRAM access SHALL occur, err SHALL be set, and the FSM SHALL stay in IDLE.
REQ-036 On a read with rd_len==0 or rd_addr+rd_len>DEPTH (computed at ADDR_W+1 bits): rd_ack and rd_done SHALL pulse in the same cycle, no access SHALL occur, err SHALL be set, and the FSM SHALL stay in IDLE.
REQ-037 The last-grant toggle SHALL update only on real grants, including error-rejected ones.
REQ-038 If err_clr and an error occur in the same cycle, err SHALL end set (error wins).
REQ-039 A burst SHALL never be preempted; wr_valid during READ or DRAIN SHALL wait with wr_ready=0.

Reset
REQ-040 While rst_n=0 and after release: FSM=IDLE, mem_cs=0, mem_oe=0, mem_web=1, mem_addr=0, mem_wdata=0, wr_ready=0, rd_ack=0, rd_dvalid=0, rd_done=0, err=0, and the last grant SHALL favour the next write.
REQ-041 Reset asserted mid-burst SHALL abort the burst immediately; no rd_done SHALL be issued and no further rd_dvalid SHALL appear.

Verification
REQ-042 Write 0x1234 at 0x08000 then read len 1 at 0x08000 -> exactly one WRITE cycle with web=0; rd_dvalid one cycle after the issue with rd_data=0x1234 and rd_done in the same cycle.
REQ-043 Burst at 0x07FFE len 4 across the bank boundary with preloaded data -> addresses 0x07FFE..0x08001 on consecutive cycles; 4 rd_dvalid in order; rd_done on the 4th.
REQ-044 rd_stall high for 3 cycles mid-burst -> no issue during the stall; rd_dvalid gap aligned with the stall; total of len valid words.
REQ-045 wr_valid and rd_req asserted together repeatedly from reset -> grants alternate W, R, W, R; a write arriving mid-burst is accepted only after DRAIN.
REQ-046 Write at 0x30000, and read at 0x2FFFF len 2 -> err=1, no mem_cs; for the read, rd_ack and rd_done pulse together; err_clr then drops err.
REQ-047 rst_n pulsed low during a 16-word burst -> all outputs return to reset values asynchronously; the next request is accepted normally.

Source files
------------

// File: rtl/weight_sram_ctrl.sv
// Weight SRAM controller: arbitrates single-word loader writes against
// multi-word fetcher read bursts onto one synchronous SRAM port.
//
// Handshakes: a write is transferred in the cycle where wr_valid and wr_ready
// are both high, and a burst is accepted in the cycle where rd_req and rd_ack
// are both high. wr_ready and rd_ack are only asserted in IDLE. They are
// combinational from the request, so a requester must hold its request and
// payload stable until it sees the acknowledge. Read data returns on
// rd_dvalid one cycle after each address issue, and rd_done marks the last
// word of a burst. A rejected burst has rd_done on the rd_ack cycle itself.
module weight_sram_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 196608,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_ack,
  input  logic              rd_stall,
  output logic              rd_dvalid,
  output logic [15:0]       rd_data,
  output logic              rd_done,
  output logic              err,
  input  logic              err_clr,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_web,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_X = AW1'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;     // write address, or current burst address
  logic [15:0]       wdata_q;
  logic [LEN_W-1:0]  remain_q;   // words still to issue, including the current one
  logic              last_rd_q;  // last grant went to the reader
  logic              issue_d_q;  // an address was issued in the previous cycle

  logic              grant_wr;
  logic              grant_rd;
  logic              wr_bad;
  logic              rd_bad;
  logic [ADDR_W:0]   rd_end;
  logic              issue;
  logic              err_set;
  logic              unused_rdata_hi;

  // Range checks, done one bit wider than the address so that the burst end can reach DEPTH.
  always_comb begin
    wr_bad = ({1'b0, wr_addr} >= DEPTH_X);
    rd_end = {1'b0, rd_addr} + AW1'(rd_len);
    rd_bad = (rd_len == '0) || (rd_end > DEPTH_X);
  end

  // Arbitration in IDLE: with both requests pending, the side that was not granted last wins.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (rst_n && (state == S_IDLE)) begin
      if (wr_valid && rd_req) begin
        grant_wr = last_rd_q;
        grant_rd = !last_rd_q;
      end else begin
        grant_wr = wr_valid;
        grant_rd = rd_req;
      end
    end
  end

  // Port-side decode from the state register, plus stall gating of the read issue.
  always_comb begin
    issue           = (state == S_READ) && !rd_stall;
    err_set         = (grant_wr && wr_bad) || (grant_rd && rd_bad);
    wr_ready        = grant_wr;
    rd_ack          = grant_rd;
    rd_done         = (state == S_DRAIN) || (grant_rd && rd_bad);
    rd_dvalid       = issue_d_q;
    rd_data         = mem_rdata[15:0];
    mem_cs          = (state == S_WRITE) || issue;
    mem_web         = (state != S_WRITE);
    mem_oe          = issue_d_q;
    mem_addr        = 32'(addr_q);
    mem_wdata       = {16'h0000, wdata_q};
    dbg_state       = state;
    unused_rdata_hi = ^mem_rdata[31:16];
  end

  // Main FSM, burst counters, error flag and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      remain_q  <= '0;
      last_rd_q <= 1'b1;
      issue_d_q <= 1'b0;
      err       <= 1'b0;
    end else begin
      issue_d_q <= issue;
      // A new error in the same cycle as err_clr leaves err set.
      err       <= (err && !err_clr) || err_set;
      if (grant_wr || grant_rd) begin
        last_rd_q <= grant_rd;
      end
      case (state)
        S_IDLE: begin
          // Rejected requests are acknowledged but leave the FSM in IDLE.
          if (grant_wr && !wr_bad) begin
            addr_q  <= wr_addr;
            wdata_q <= wr_data;
            state   <= S_WRITE;
          end else if (grant_rd && !rd_bad) begin
            addr_q   <= rd_addr;
            remain_q <= rd_len;
            state    <= S_READ;
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        S_READ: begin
          if (issue) begin
            if (remain_q == LEN_W'(1)) begin
              state <= S_DRAIN;
            end else begin
              addr_q   <= addr_q + ADDR_W'(1);
              remain_q <= remain_q - LEN_W'(1);
            end
          end
        end
        S_DRAIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Bench for weight_sram_ctrl: SRAM behavioural model, a transaction-level
// reference (word memory plus expected-read / expected-issue / expected-write
// queues), directed scenarios followed by randomized traffic.
module tb_weight_sram_ctrl;

  localparam int ADDR_W = 18;
  localparam int DEPTH  = 196608;
  localparam int LEN_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [15:0]       wr_data = '0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [LEN_W-1:0]  rd_len = '0;
  logic              rd_ack;
  logic              rd_stall = 1'b0;
  logic              rd_dvalid;
  logic [15:0]       rd_data;
  logic              rd_done;
  logic              err;
  logic              err_clr = 1'b0;
  logic              mem_cs;
  logic              mem_oe;
  logic              mem_web;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic [1:0]        dbg_state;

  weight_sram_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
    .rd_stall(rd_stall), .rd_dvalid(rd_dvalid), .rd_data(rd_data), .rd_done(rd_done),
    .err(err), .err_clr(err_clr),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- SRAM model (one-cycle read latency) ----------------
  bit [15:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_cs && (mem_addr < 32'(DEPTH))) begin
      if (!mem_web) sram[int'(mem_addr)] <= mem_wdata[15:0];
      else          mem_rdata <= {16'hA5C3, sram[int'(mem_addr)]};
    end
  end

  // ---------------- reference model / scoreboard ----------------
  bit [15:0]   ref_mem [DEPTH];
  logic [15:0] exp_q[$];        // words the current burst must return, in order
  logic [31:0] exp_addr_q[$];   // addresses the current burst must still issue
  logic [47:0] exp_wr_q[$];     // {addr, data} of the accepted write not yet seen at the SRAM
  bit          dut_log[$];      // DUT grants in order: 0 = write, 1 = read
  bit          favor_wr;
  bit          model_err;
  bit          prev_issue;
  int          n_checks = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_addr_q.delete();
    exp_wr_q.delete();
    favor_wr   = 1'b1;
    model_err  = 1'b0;
    prev_issue = 1'b0;
  endtask

  // Cycle monitor: compares every port against the transaction model.
  always @(negedge clk) begin
    if (rst_n) begin
      bit wr_pend, rd_issue, idle, exp_w, exp_r, bad, last_word, err_ev;
      logic [47:0] we;
      logic [15:0] d;
      wr_pend  = exp_wr_q.size() > 0;
      rd_issue = (exp_addr_q.size() > 0) && !rd_stall;
      idle     = !wr_pend && (exp_addr_q.size() == 0) && (exp_q.size() == 0);

      check_eq("mem_cs", mem_cs, wr_pend || rd_issue);
      check_eq("mem_web", mem_web, !wr_pend);
      check_eq("mem_oe", mem_oe, prev_issue);
      check_eq("rd_dvalid", rd_dvalid, prev_issue);
      if (wr_pend) begin
        we = exp_wr_q.pop_front();
        check_eq("sram_wr_addr", mem_addr, we[47:16]);
        check_eq("sram_wr_data", mem_wdata, {16'h0, we[15:0]});
      end
      if (rd_issue) check_eq("rd_issue_addr", mem_addr, exp_addr_q.pop_front());

      last_word = 1'b0;
      if (rd_dvalid) begin
        if (exp_q.size() == 0) check_eq("rd_dvalid_unexpected", rd_dvalid, 0);
        else begin
          d = exp_q.pop_front();
          check_eq("rd_data", rd_data, d);
          last_word = (exp_q.size() == 0);
        end
      end

      exp_w = 1'b0;
      exp_r = 1'b0;
      if (idle) begin
        if (wr_valid && rd_req) begin
          exp_w = favor_wr;
          exp_r = !favor_wr;
        end else begin
          exp_w = wr_valid;
          exp_r = rd_req;
        end
      end
      check_eq("wr_ready", wr_ready, exp_w);
      check_eq("rd_ack", rd_ack, exp_r);
      if (wr_ready) dut_log.push_back(1'b0);
      if (rd_ack)   dut_log.push_back(1'b1);

      err_ev = 1'b0;
      bad    = 1'b0;
      if (exp_w) begin
        favor_wr = 1'b0;
        if (int'(wr_addr) >= DEPTH) err_ev = 1'b1;
        else begin
          ref_mem[int'(wr_addr)] = wr_data;
          exp_wr_q.push_back({32'(wr_addr), wr_data});
        end
      end
      if (exp_r) begin
        favor_wr = 1'b1;
        bad = (rd_len == 0) || (int'(rd_addr) + int'(rd_len) > DEPTH);
        if (bad) err_ev = 1'b1;
        else begin
          for (int i = 0; i < int'(rd_len); i++) begin
            exp_addr_q.push_back(32'(int'(rd_addr) + i));
            exp_q.push_back(ref_mem[int'(rd_addr) + i]);
          end
        end
      end
      check_eq("rd_done", rd_done, last_word || (exp_r && bad));
      check_eq("err", err, model_err);
      model_err  = (model_err && !err_clr) || err_ev;
      prev_issue = rd_issue;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit is_wr, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (is_wr ? wr_ready : rd_ack) seen = 1'b1;
      tick();
    end
  endtask

  task automatic wait_idle(input int stall_mode);
    for (int c = 0; c < 400 && (exp_q.size() > 0 || exp_addr_q.size() > 0); c++) begin
      case (stall_mode)
        1:       rd_stall = ($urandom_range(0, 3) == 0);
        2:       rd_stall = (c >= 2 && c < 5);
        default: rd_stall = 1'b0;
      endcase
      tick();
    end
    rd_stall = 1'b0;
    check_eq("burst_finish_timeout", exp_q.size() + exp_addr_q.size(), 0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [15:0] dat);
    bit seen;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = dat;
    wait_grant(1'b1, seen);
    wr_valid = 1'b0;
    check_eq("wr_accept_timeout", seen, 1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len, input int stall_mode);
    bit seen;
    rd_req  = 1'b1;
    rd_addr = a;
    rd_len  = len;
    wait_grant(1'b0, seen);
    rd_req = 1'b0;
    check_eq("rd_accept_timeout", seen, 1);
    wait_idle(stall_mode);
  endtask

  task automatic both_req(input logic [ADDR_W-1:0] wa, input logic [15:0] wd,
                          input logic [ADDR_W-1:0] ra, input logic [LEN_W-1:0] rl);
    bit w, r;
    wr_valid = 1'b1; wr_addr = wa; wr_data = wd;
    rd_req   = 1'b1; rd_addr = ra; rd_len  = rl;
    for (int i = 0; i < 200 && (wr_valid || rd_req); i++) begin
      @(negedge clk);
      w = wr_ready;
      r = rd_ack;
      tick();
      if (w) wr_valid = 1'b0;
      if (r) rd_req = 1'b0;
    end
    check_eq("both_req_timeout", {wr_valid, rd_req}, 0);
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    wait_idle(0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_mem_cs"}, mem_cs, 0);
    check_eq({tag, "_mem_oe"}, mem_oe, 0);
    check_eq({tag, "_mem_web"}, mem_web, 1);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "_wr_ready"}, wr_ready, 0);
    check_eq({tag, "_rd_ack"}, rd_ack, 0);
    check_eq({tag, "_rd_dvalid"}, rd_dvalid, 0);
    check_eq({tag, "_rd_done"}, rd_done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    int pend;
    logic [ADDR_W-1:0] a;
    int base;
    int kind;
    bit exp_order0 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit exp_order1 [3] = '{1'b0, 1'b1, 1'b0};

    reset_model();
    rst_n    = 1'b0;
    wr_valid = 1'b1;  // a request during reset must not be acknowledged
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    wr_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Simultaneous requests from reset: write first, then alternate.
    dut_log.delete();
    both_req(18'h08000, 16'h1234, 18'h08000, 16'd1);
    both_req(18'h07FFE, 16'hA001, 18'h07FFE, 16'd1);
    check_eq("grant_count_a", dut_log.size(), 4);
    for (int i = 0; i < 4 && i < dut_log.size(); i++) check_eq($sformatf("grant_order_a%0d", i), dut_log[i], exp_order0[i]);

    // After a lone write, a simultaneous pair must go to the reader first.
    dut_log.delete();
    do_write(18'h07FFF, 16'hA002);
    both_req(18'h08001, 16'hA004, 18'h00100, 16'd2);
    check_eq("grant_count_b", dut_log.size(), 3);
    for (int i = 0; i < 3 && i < dut_log.size(); i++) check_eq($sformatf("grant_order_b%0d", i), dut_log[i], exp_order1[i]);
    check_eq("grant_order_b3", dut_log.size() > 1 ? dut_log[1] : 1'b0, 1);

    // Burst across the bank boundary, then the same burst with a 3-cycle stall.
    do_read(18'h07FFE, 16'd4, 0);
    do_read(18'h07FFE, 16'd4, 2);

    // Write arriving mid-burst waits until the burst has drained.
    rd_addr = 18'h07FF8; rd_len = 16'd8; rd_req = 1'b1;
    wait_grant(1'b0, seen);
    rd_req = 1'b0;
    check_eq("mid_burst_rd_accept", seen, 1);
    wr_valid = 1'b1; wr_addr = 18'h00300; wr_data = 16'h5A5A;
    seen = 1'b0;
    pend = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        seen = 1'b1;
        pend = exp_q.size() + exp_addr_q.size();
      end
      tick();
    end
    wr_valid = 1'b0;
    check_eq("mid_burst_wr_accept", seen, 1);
    check_eq("mid_burst_wr_after_drain", pend, 0);
    tick();

    // Error handling: out-of-range write, out-of-range read, then clear.
    do_write(18'h30000, 16'hBEEF);
    check_eq("err_after_bad_wr", err, 1);
    do_read(18'h2FFFF, 16'd2, 0);
    check_eq("err_after_bad_rd", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("err_cleared", err, 0);
    do_read(18'h2FFFE, 16'd2, 0);   // ends exactly at DEPTH: legal
    check_eq("err_last_words_legal", err, 0);
    do_read(18'h00010, 16'd0, 0);   // zero length: rejected
    check_eq("err_after_zero_len", err, 1);

    // Randomized traffic around the bank and end-of-memory boundaries.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 2))
        0:       base = 0;
        1:       base = 32'h7FE0;
        default: base = 32'h2FFC0;
      endcase
      a = ADDR_W'(base + int'($urandom_range(0, 63)));
      kind = int'($urandom_range(0, 11));
      err_clr = ($urandom_range(0, 4) == 0);
      if (kind <= 3)       do_write(a, 16'($urandom_range(0, 65535)));
      else if (kind == 4)  do_write(ADDR_W'(DEPTH + int'($urandom_range(0, 100))), 16'($urandom_range(0, 65535)));
      else if (kind <= 8)  do_read(a, LEN_W'($urandom_range(1, 8)), int'($urandom_range(0, 1)));
      else if (kind == 9)  do_read(a, 16'd0, 0);
      else                 both_req(a, 16'($urandom_range(0, 65535)), ADDR_W'(base), LEN_W'($urandom_range(1, 6)));
      err_clr = 1'b0;
      if ($urandom_range(0, 2) == 0) tick();
    end

    // Reset in the middle of a 16-word burst aborts it at once.
    rd_addr = 18'h07FF4; rd_len = 16'd16; rd_req = 1'b1;
    wait_grant(1'b0, seen);
    rd_req = 1'b0;
    check_eq("abort_rd_accept", seen, 1);
    for (int i = 0; i < 50 && exp_q.size() > 12; i++) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_reset_vals("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    dut_log.delete();
    both_req(18'h00400, 16'h0F0F, 18'h00400, 16'd3);
    check_eq("post_reset_grants", dut_log.size(), 2);
    check_eq("post_reset_write_first", dut_log.size() > 0 ? dut_log[0] : 1'b1, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
